// File: rtl/reg_bus_sequencer_pkg.sv
// Shared types and default sizing for the register-bus sequencer.
// The package holds the FSM state encoding and the settle-counter helpers.
package reg_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_ADDR_WIDTH    = 3;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_NUM_LINES     = 6;
  localparam int DEF_SETTLE_CYCLES = 1;
  localparam int CNT_WIDTH         = 4;

  // Counter reload: SETTLE lasts settle_cycles clocks, ending when the count reaches zero.
  function automatic logic [CNT_WIDTH-1:0] settle_load(input int settle);
    return CNT_WIDTH'(settle - 1);
  endfunction

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// CPU-side memory-mapped transfer bus with Avalon-style wait-request.
// The master modport is the CPU; the slave modport is the sequencer.
interface reg_bus_sequencer_if
  import reg_bus_sequencer_pkg::*;
#(
  parameter int addr_width = DEF_ADDR_WIDTH,
  parameter int data_width = DEF_DATA_WIDTH
);

  logic [addr_width-1:0] cpu_address;
  logic                  cpu_read;
  logic                  cpu_write;
  logic [data_width-1:0] cpu_writedata;
  logic [data_width-1:0] cpu_readdata;
  logic                  cpu_waitrequest;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata,
    input  cpu_readdata, cpu_waitrequest
  );

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata,
    output cpu_readdata, cpu_waitrequest
  );

endinterface

// File: rtl/reg_bus_sequencer.sv
// Bus front end for the register slave fan-out: latches a CPU transfer, holds the
// decoder address through its select latency, strobes the line, then completes.
module reg_bus_sequencer
  import reg_bus_sequencer_pkg::*;
#(
  parameter int addr_width    = DEF_ADDR_WIDTH,
  parameter int data_width    = DEF_DATA_WIDTH,
  parameter int num_lines     = DEF_NUM_LINES,
  parameter int settle_cycles = DEF_SETTLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  reg_bus_sequencer_if.slave    cpu,
  output logic [addr_width-1:0] dec_address,
  output logic                  wr_strobe,
  output logic                  rd_strobe,
  output logic [data_width-1:0] wr_data,
  input  logic [data_width-1:0] rd_data,
  output logic                  access_err
);

  state_t                state;
  logic [CNT_WIDTH-1:0]  count;
  logic                  is_write;
  logic                  in_range;
  logic [data_width-1:0] readdata;
  logic                  waitrequest;
  logic                  req_in_range;

  assign cpu.cpu_readdata    = readdata;
  assign cpu.cpu_waitrequest = waitrequest;

  // Range check is resolved at accept time so ACCESS works only from latched state.
  assign req_in_range = (32'(cpu.cpu_address) < 32'(num_lines));

  // Strobes and waitrequest are flops set on the transition into ACCESS/DONE,
  // so they coincide with those states and cannot glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      count       <= '0;
      is_write    <= 1'b0;
      in_range    <= 1'b0;
      dec_address <= '0;
      wr_data     <= '0;
      readdata    <= '0;
      wr_strobe   <= 1'b0;
      rd_strobe   <= 1'b0;
      waitrequest <= 1'b1;
      access_err  <= 1'b0;
    end else begin
      wr_strobe   <= 1'b0;
      rd_strobe   <= 1'b0;
      waitrequest <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (cpu.cpu_read || cpu.cpu_write) begin
            dec_address <= cpu.cpu_address;
            wr_data     <= cpu.cpu_writedata;
            is_write    <= cpu.cpu_write;
            in_range    <= req_in_range;
            count       <= settle_load(settle_cycles);
            if (cpu.cpu_read && cpu.cpu_write) begin
              access_err <= 1'b1;
            end
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (count == '0) begin
            wr_strobe <= in_range && is_write;
            rd_strobe <= in_range && !is_write;
            state     <= ST_ACCESS;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_ACCESS: begin
          if (!in_range) begin
            readdata   <= '0;
            access_err <= 1'b1;
          end else if (!is_write) begin
            readdata <= rd_data;
          end
          waitrequest <= 1'b0;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Self-checking bench: a vector table of transfers plus hand-written reset and
// settle-latency sequences, with expected completions kept in a scoreboard queue.
module tb_reg_bus_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_bus_sequencer_if #(.addr_width(3), .data_width(8)) a_if ();
  reg_bus_sequencer_if #(.addr_width(3), .data_width(8)) b_if ();

  logic [2:0] a_dec_address, b_dec_address;
  logic       a_wr_strobe, b_wr_strobe, a_rd_strobe, b_rd_strobe;
  logic [7:0] a_wr_data, b_wr_data, a_rd_data, b_rd_data;
  logic       a_access_err, b_access_err;

  reg_bus_sequencer #(.addr_width(3), .data_width(8), .num_lines(6), .settle_cycles(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .cpu(a_if),
    .dec_address(a_dec_address), .wr_strobe(a_wr_strobe), .rd_strobe(a_rd_strobe),
    .wr_data(a_wr_data), .rd_data(a_rd_data), .access_err(a_access_err)
  );

  reg_bus_sequencer #(.addr_width(3), .data_width(8), .num_lines(6), .settle_cycles(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .cpu(b_if),
    .dec_address(b_dec_address), .wr_strobe(b_wr_strobe), .rd_strobe(b_rd_strobe),
    .wr_data(b_wr_data), .rd_data(b_rd_data), .access_err(b_access_err)
  );

  typedef struct {
    logic       rd;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       exp_wr;
    logic       exp_rd;
    logic [7:0] exp_readdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit use_b, input logic rd, input logic wr, input logic [2:0] addr,
                       input logic [7:0] wdata, input logic [7:0] rdata);
    if (use_b) begin
      b_if.cpu_read = rd; b_if.cpu_write = wr; b_if.cpu_address = addr;
      b_if.cpu_writedata = wdata; b_rd_data = rdata;
    end else begin
      a_if.cpu_read = rd; a_if.cpu_write = wr; a_if.cpu_address = addr;
      a_if.cpu_writedata = wdata; a_rd_data = rdata;
    end
  endtask

  task automatic sample(input bit use_b, output logic ws, output logic rs, output logic wq,
                        output logic [2:0] da, output logic [7:0] wd, output logic [7:0] rdd,
                        output logic er);
    if (use_b) begin
      ws = b_wr_strobe; rs = b_rd_strobe; wq = b_if.cpu_waitrequest;
      da = b_dec_address; wd = b_wr_data; rdd = b_if.cpu_readdata; er = b_access_err;
    end else begin
      ws = a_wr_strobe; rs = a_rd_strobe; wq = a_if.cpu_waitrequest;
      da = a_dec_address; wd = a_wr_data; rdd = a_if.cpu_readdata; er = a_access_err;
    end
  endtask

  task automatic xfer(input string tag, input vec_t v, input bit use_b, input int settle);
    vec_t e;
    logic ws, rs, wq, er;
    logic [2:0] da, da_strobe;
    logic [7:0] wd, rdd, wd_strobe;
    int wr_cnt = 0, rd_cnt = 0, strobe_at = -1, wait_at = -1;
    exp_q.push_back(v);
    @(negedge clk);
    drive(use_b, v.rd, v.wr, v.addr, v.wdata, v.rdata);
    @(posedge clk); #1;
    sample(use_b, ws, rs, wq, da, wd, rdd, er);
    check({tag, " accept dec_address"}, 32'(da), 32'(v.addr));
    // Drop the request and scramble address/data: the latched copy must win.
    drive(use_b, 1'b0, 1'b0, v.addr ^ 3'b101, ~v.wdata, v.rdata);
    da_strobe = '0;
    wd_strobe = '0;
    for (int k = 1; k <= 24 && wait_at < 0; k++) begin
      @(posedge clk); #1;
      sample(use_b, ws, rs, wq, da, wd, rdd, er);
      if (ws) wr_cnt++;
      if (rs) rd_cnt++;
      if ((ws || rs) && strobe_at < 0) begin
        strobe_at = k; da_strobe = da; wd_strobe = wd;
      end
      if (!wq) wait_at = k;
    end
    e = exp_q.pop_front();
    check({tag, " wr_strobe count"}, 32'(wr_cnt), 32'(e.exp_wr));
    check({tag, " rd_strobe count"}, 32'(rd_cnt), 32'(e.exp_rd));
    if (e.exp_wr || e.exp_rd) begin
      check({tag, " strobe cycle"}, 32'(strobe_at), 32'(settle));
      check({tag, " strobe dec_address"}, 32'(da_strobe), 32'(e.addr));
    end
    if (e.exp_wr) check({tag, " strobe wr_data"}, 32'(wd_strobe), 32'(e.wdata));
    check({tag, " waitrequest low cycle"}, 32'(wait_at), 32'(settle + 1));
    check({tag, " readdata"}, 32'(rdd), 32'(e.exp_readdata));
    check({tag, " access_err"}, 32'(er), 32'(e.exp_err));
    @(posedge clk); #1;
    sample(use_b, ws, rs, wq, da, wd, rdd, er);
    check({tag, " waitrequest back high"}, 32'(wq), 32'd1);
    $display("xfer %s: rd=%0b wr=%0b addr=%0d wdata=%02h -> readdata=%02h err=%0b strobe@%0d wait@%0d",
             tag, e.rd, e.wr, e.addr, e.wdata, rdd, er, strobe_at, wait_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ws, rs, wq, er;
    logic [2:0] da;
    logic [7:0] wd, rdd;
    int bad;
    vec_t hv;

    //           rd    wr    addr  wdata  rdata  exp_wr exp_rd readdata err
    vecs[0] = '{1'b0, 1'b1, 3'd2, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 3'd5, 8'h00, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 3'd0, 8'h5A, 8'hEE, 1'b1, 1'b0, 8'h3C, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 3'd7, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 3'd3, 8'h00, 8'h77, 1'b0, 1'b1, 8'h77, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 3'd6, 8'h00, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 3'd6, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 3'd4, 8'h00, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 3'd7, 8'h33, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    sample(1'b0, ws, rs, wq, da, wd, rdd, er);
    check("reset dec_address", 32'(da), 32'd0);
    check("reset wr_data", 32'(wd), 32'd0);
    check("reset readdata", 32'(rdd), 32'd0);
    check("reset strobes", 32'({ws, rs}), 32'd0);
    check("reset waitrequest", 32'(wq), 32'd1);
    check("reset access_err", 32'(er), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      xfer($sformatf("vec%0d", i), vecs[i], 1'b0, 1);
    end

    // Reset while SETTLE holds a nonzero address, write data and a sticky error.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 3'd2, 8'h96, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'd2, 8'h96, 8'h00);
    #2 reset_n = 1'b0;
    #1;
    sample(1'b0, ws, rs, wq, da, wd, rdd, er);
    check("midreset dec_address", 32'(da), 32'd0);
    check("midreset wr_data", 32'(wd), 32'd0);
    check("midreset strobes", 32'({ws, rs}), 32'd0);
    check("midreset waitrequest", 32'(wq), 32'd1);
    check("midreset access_err", 32'(er), 32'd0);
    $display("xfer midreset: reset_n asserted during SETTLE");
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      sample(1'b0, ws, rs, wq, da, wd, rdd, er);
      if (ws || rs || !wq) bad++;
    end
    check("post-reset idle quiet cycles", 32'(bad), 32'd0);

    hv = '{1'b1, 1'b1, 3'd1, 8'h99, 8'h44, 1'b1, 1'b0, 8'h00, 1'b1};
    xfer("both_high", hv, 1'b0, 1);

    // Slow decoder: address swapped 1->4 after accept, strobe must still target 1.
    hv = '{1'b0, 1'b1, 3'd1, 8'h42, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    xfer("settle3_addr_change", hv, 1'b1, 3);
    hv = '{1'b1, 1'b0, 3'd5, 8'h00, 8'h6B, 1'b0, 1'b1, 8'h6B, 1'b0};
    xfer("settle3_read", hv, 1'b1, 3);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bus_sequencer.md
# reg_bus_sequencer

Bus-side front end for the synth's register slave fan-out. Accepts single read/write transfers from the CPU-side memory-mapped master, drives a held address to the downstream registered address decoder, and waits out the decoder's select latency. It then issues a one-cycle write or read strobe to the selected slave line and completes the transfer with an Avalon-style wait-request handshake.

## Interface
- addr_width, 3: width of CPU and decoder address.
- data_width, 8: register data width.
- num_lines, 6: number of decoded slave lines; addresses >= num_lines are out of range.
- settle_cycles, 1: decoder select latency in clocks, 1..15.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- cpu_address  in  addr_width  transfer address.
- cpu_read  in  1  read request.
- cpu_write  in  1  write request.
- cpu_writedata  in  data_width  write data.
- cpu_readdata  out  data_width  read data, valid while cpu_waitrequest=0 after a read.
- cpu_waitrequest  out  1  high = master must hold request.
- dec_address  out  addr_width  latched address to decoder.
- wr_strobe  out  1  one-cycle write pulse to selected line.
- rd_strobe  out  1  one-cycle read pulse to selected line.
- wr_data  out  data_width  latched write data.
- rd_data  in  data_width  read data from selected line, sampled at end of rd_strobe cycle.
- access_err  out  1  sticky protocol/address error flag.

## Operation
- States: IDLE, SETTLE, ACCESS, DONE.
- IDLE: cpu_waitrequest=1. On cpu_read|cpu_write, latch cpu_address→dec_address, cpu_writedata→wr_data, op (write if cpu_write), load settle counter with settle_cycles-1, go SETTLE.
- Both read and write high: treated as write; access_err set.
- SETTLE: hold dec_address; decrement counter; at 0 go ACCESS.
- ACCESS: if latched address < num_lines, assert wr_strobe (write) or rd_strobe (read) for exactly this cycle; a read captures rd_data into cpu_readdata at the end of this cycle. If out of range: no strobe, cpu_readdata←0, access_err set. Go DONE.
- DONE: cpu_waitrequest=0 for exactly one cycle; go IDLE.
- Request inputs are ignored outside IDLE; the latched copy is authoritative even if the master drops or changes the request mid-transfer.
- A request still high in IDLE after DONE is a new transfer.
- access_err clears only on reset.
- cpu_readdata holds its value until the next read or out-of-range access.

## Timing
- Reset values: dec_address 0, wr_data 0, cpu_readdata 0, wr_strobe 0, rd_strobe 0, cpu_waitrequest 1, access_err 0, state IDLE, counter 0.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at reset values. No strobe is emitted after reset release until a new request.
- Request sampled at edge E0 → dec_address valid after E0 → strobe in cycle E0+settle_cycles+1 → cpu_waitrequest low in cycle E0+settle_cycles+2.
- Transfer length: settle_cycles+3 clocks including the IDLE accept cycle. Back-to-back throughput is one transfer per settle_cycles+3 clocks.
- Strobes and cpu_waitrequest are decoded from the registered state only, so they are glitch-free. Strobe and waitrequest-low are never in the same cycle.

## Structure
- Shared package: state enum typedef (2 bits), default width constants.
- Single module: FSM plus a 4-bit settle counter.
- The decoder is instantiated beside this block by the parent, not inside it.

## Test plan
- Write addr 2, data 8'hA5, settle_cycles=1: dec_address=2 from next cycle; wr_strobe high one cycle with wr_data=A5, 2 clocks after accept; waitrequest low one cycle after that; access_err=0.
- Read addr 5, rd_data=8'h3C during strobe: cpu_readdata=3C when waitrequest low; no wr_strobe.
- Read addr 7 (num_lines=6): no strobes; cpu_readdata=0; access_err=1 and stays 1 across later good transfers.
- cpu_read and cpu_write both high, addr 1: write strobe issued; access_err=1.
- Master changes cpu_address 1→4 during SETTLE: strobe still targets dec_address=1. With settle_cycles=3, strobe appears 4 cycles after accept.
- reset_n low during SETTLE: outputs at reset values same cycle; after release with no request, wr_strobe/rd_strobe stay 0 and cpu_waitrequest=1.
